ysyx_22040931_mem_arbiter: RTL

- Shares the core's single memory port between instruction fetch (IF, read-only) and the load/store requests produced by the EX stage.
- Runs the request/response handshake on the memory side.
- LSU path: builds byte-lane write data and mask from the store op, and extracts and sign/zero-extends load data from the load op.
- Sits between IF/EX/MEM and the external memory model or AXI bridge. Only one transaction is outstanding at a time.

---
 rtl/ysyx_22040931_mem_arbiter_pkg.sv | 59 +++++
 rtl/ysyx_22040931_lsu_fmt.sv | 46 ++++
 rtl/ysyx_22040931_mem_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040931_mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - store/load op encodings as seen on ls_wop / ls_rop
//   - memory data width
//   - arbiter FSM states and grant identifiers
//   - misalignment rule shared by the LSU formatter
package ysyx_22040931_mem_arbiter_pkg;

  localparam int unsigned DATA_W = 64;

  // Store ops (ls_wop); codes 1xx behave as SD
  localparam logic [2:0] OP_SB  = 3'b000;
  localparam logic [2:0] OP_SH  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_SD  = 3'b011;

  // Load ops (ls_rop); code 111 behaves as LD
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_LWU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } grant_t;

  // Natural alignment check for the access size implied by op.
  function automatic logic misaligned(input logic wr, input logic [2:0] op,
                                      input logic [2:0] off);
    logic mis;
    if (wr) begin
      case (op)
        OP_SB:   mis = 1'b0;
        OP_SH:   mis = off[0];
        OP_SW:   mis = |off[1:0];
        default: mis = |off;
      endcase
    end else begin
      case (op)
        OP_LB, OP_LBU: mis = 1'b0;
        OP_LH, OP_LHU: mis = off[0];
        OP_LW, OP_LWU: mis = |off[1:0];
        default:       mis = |off;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_22040931_lsu_fmt.sv
// Combinational LSU data formatter.
// Inputs : wr (1=store), op (ls_wop or ls_rop code), offset (addr[2:0]),
//          wdata (LSB-justified store data), rdata (aligned 8-byte word).
// Outputs: wmask (byte-lane enables), wdata_sh (lane-shifted store data),
//          rdata_ext (shifted and extended load data), misalign.
module ysyx_22040931_lsu_fmt
  import ysyx_22040931_mem_arbiter_pkg::*;
(
  input  logic              wr,
  input  logic [2:0]        op,
  input  logic [2:0]        offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [7:0]        wmask,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misalign
);

  logic [DATA_W-1:0] rdata_sh;

  always_comb begin
    case (op)
      OP_SB:   wmask = 8'h01 << offset;
      OP_SH:   wmask = 8'h03 << offset;
      OP_SW:   wmask = 8'h0f << offset;
      default: wmask = 8'hff;
    endcase

    wdata_sh = wdata << {offset, 3'b000};
    rdata_sh = rdata >> {offset, 3'b000};

    case (op)
      OP_LB:   rdata_ext = {{56{rdata_sh[7]}},  rdata_sh[7:0]};
      OP_LH:   rdata_ext = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      OP_LW:   rdata_ext = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      OP_LBU:  rdata_ext = {56'b0, rdata_sh[7:0]};
      OP_LHU:  rdata_ext = {48'b0, rdata_sh[15:0]};
      OP_LWU:  rdata_ext = {32'b0, rdata_sh[31:0]};
      default: rdata_ext = rdata_sh;
    endcase

    misalign = misaligned(wr, op, offset);
  end

endmodule

// File: rtl/ysyx_22040931_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr -> if_done/if_inst
//                                   fetch request, completion pulse, instruction
//   ls_req/ls_wr/ls_addr/ls_wop/ls_rop/ls_wdata -> ls_done/ls_rdata/ls_misalign
//                                   load/store request, completion pulse, data
//   mem_req_*                       request channel (valid/ready handshake)
//   mem_rsp_valid/mem_rsp_rdata     single-cycle response channel
// One transaction outstanding at a time; conflicting requests alternate,
// with the first conflict after reset going to the LSU.
module ysyx_22040931_mem_arbiter
  import ysyx_22040931_mem_arbiter_pkg::*;
#(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned MEM_AW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [PC_W-1:0]   if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [MEM_AW-1:0] ls_addr,
  input  logic [2:0]        ls_wop,
  input  logic [2:0]        ls_rop,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_misalign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [MEM_AW-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
);

  state_t      state;
  grant_t      grant;
  grant_t      last_grant;
  grant_t      pick;
  logic        lat_wr;
  logic [2:0]  lat_op;
  logic [2:0]  lat_off;
  logic        if_hi;
  logic        mis_pending;

  logic              fmt_wr;
  logic [2:0]        fmt_op;
  logic [2:0]        fmt_off;
  logic [7:0]        fmt_wmask;
  logic [DATA_W-1:0] fmt_wdata;
  logic [DATA_W-1:0] fmt_rdata;
  logic              fmt_mis;

  // Address bits outside the bus width and below word granularity are ignored.
  logic unused_if_addr;
  assign unused_if_addr = ^{if_addr[PC_W-1:MEM_AW], if_addr[1:0]};

  always_comb begin
    pick = GNT_IF;
    if (if_req && ls_req) begin
      if (last_grant == GNT_IF) pick = GNT_LS;
      else                      pick = GNT_IF;
    end else if (ls_req) begin
      pick = GNT_LS;
    end
  end

  // The formatter sees the live LSU inputs while granting (mask, shifted
  // data, alignment) and the latched op/offset afterwards (load extension).
  always_comb begin
    if (state == S_IDLE) begin
      fmt_wr  = ls_wr;
      fmt_op  = ls_wr ? ls_wop : ls_rop;
      fmt_off = ls_addr[2:0];
    end else begin
      fmt_wr  = lat_wr;
      fmt_op  = lat_op;
      fmt_off = lat_off;
    end
  end

  ysyx_22040931_lsu_fmt u_fmt (
    .wr        (fmt_wr),
    .op        (fmt_op),
    .offset    (fmt_off),
    .wdata     (ls_wdata),
    .rdata     (mem_rsp_rdata),
    .wmask     (fmt_wmask),
    .wdata_sh  (fmt_wdata),
    .rdata_ext (fmt_rdata),
    .misalign  (fmt_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      grant         <= GNT_IF;
      last_grant    <= GNT_IF;
      lat_wr        <= 1'b0;
      lat_op        <= '0;
      lat_off       <= '0;
      if_hi         <= 1'b0;
      mis_pending   <= 1'b0;
      if_done       <= 1'b0;
      if_inst       <= '0;
      ls_done       <= 1'b0;
      ls_rdata      <= '0;
      ls_misalign   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else begin
      if_done     <= 1'b0;
      ls_done     <= 1'b0;
      ls_misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_req || ls_req) begin
            grant      <= pick;
            last_grant <= pick;
            if (pick == GNT_LS) begin
              lat_wr  <= ls_wr;
              lat_op  <= fmt_op;
              lat_off <= ls_addr[2:0];
              if (fmt_mis) begin
                mis_pending <= 1'b1;
                state       <= S_DONE;
              end else begin
                mem_req_valid <= 1'b1;
                mem_req_wr    <= ls_wr;
                mem_req_addr  <= {ls_addr[MEM_AW-1:3], 3'b000};
                mem_req_wdata <= ls_wr ? fmt_wdata : '0;
                mem_req_wmask <= ls_wr ? fmt_wmask : '0;
                state         <= S_REQ;
              end
            end else begin
              if_hi         <= if_addr[2];
              mem_req_valid <= 1'b1;
              mem_req_wr    <= 1'b0;
              mem_req_addr  <= {if_addr[MEM_AW-1:3], 3'b000};
              mem_req_wdata <= '0;
              mem_req_wmask <= '0;
              state         <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (grant == GNT_IF) begin
              if_inst <= if_hi ? mem_rsp_rdata[63:32] : mem_rsp_rdata[31:0];
              if_done <= 1'b1;
            end else begin
              ls_rdata <= lat_wr ? '0 : fmt_rdata;
              ls_done  <= 1'b1;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // A misaligned access spends one silent cycle here before its
          // pulse, so it completes two cycles after the grant.
          if (mis_pending) begin
            mis_pending <= 1'b0;
            ls_done     <= 1'b1;
            ls_misalign <= 1'b1;
            ls_rdata    <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
